// File: rtl/common.sv
// rtl/common.sv - shared framebuffer color index definitions
package common_pkg;
  localparam int COLOR_WIDTH = 4;

  localparam logic [COLOR_WIDTH-1:0] COLOR_BLACK = 4'd0;
  localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE = 4'd1;
  localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 4'd2;
  localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 4'd3;
  localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 4'd4;
endpackage

// File: rtl/pixel_write_arbiter.sv
// rtl/pixel_write_arbiter.sv - round-robin framebuffer write arbiter with bounded burst lock (optional PIXEL_COLOR_CHECK_EN)
module pixel_write_arbiter
  import common_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int X_WIDTH   = 10,
  parameter int Y_WIDTH   = 9,
  parameter int MAX_BURST = 16,
  localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ*X_WIDTH-1:0]     req_x,
  input  logic [NUM_REQ*Y_WIDTH-1:0]     req_y,
  input  logic [NUM_REQ*COLOR_WIDTH-1:0] req_color,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           fb_valid,
  input  logic                           fb_ready,
  output logic [X_WIDTH-1:0]             fb_x,
  output logic [Y_WIDTH-1:0]             fb_y,
  output logic [COLOR_WIDTH-1:0]         fb_color,
  output logic [SRC_W-1:0]               fb_src,
  output logic                           color_err
);

  logic [SRC_W-1:0]       ptr;
  logic [SRC_W-1:0]       owner;
  logic [SRC_W-1:0]       gidx;
  logic [SRC_W-1:0]       cand;
  logic [SRC_W-1:0]       ptr_next;
  logic                   locked;
  logic                   lock_hold;
  logic                   found;
  logic                   accept;
  logic                   transfer;
  logic [7:0]             burst_cnt;
  logic [8:0]             burst_next;
  logic [X_WIDTH-1:0]     sel_x;
  logic [Y_WIDTH-1:0]     sel_y;
  logic [COLOR_WIDTH-1:0] sel_color;
  logic [COLOR_WIDTH-1:0] wr_color;

  // The output stage can take a new write when empty or draining this cycle.
  assign accept    = !fb_valid || fb_ready;
  // A lock only holds while its owner keeps asking; otherwise the scan takes over at once.
  assign lock_hold = locked && req_valid[owner];
  assign transfer  = found && accept;
  assign ptr_next  = SRC_W'((int'(gidx) + 1) % NUM_REQ);
  // A fresh lock run always counts from zero, even if another owner's run just ended.
  assign burst_next = (lock_hold ? {1'b0, burst_cnt} : 9'd0) + 9'd1;

  // Pick the winner: locked owner first, else first valid requester from the pointer upward.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    if (lock_hold) begin
      found = 1'b1;
      gidx  = owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = SRC_W'((int'(ptr) + k) % NUM_REQ);
        if (!found && req_valid[cand]) begin
          found = 1'b1;
          gidx  = cand;
        end
      end
    end
  end

  // Route the winner's payload and raise its ready when the output stage can accept.
  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == SRC_W'(i)) begin
        sel_x        = req_x[i*X_WIDTH +: X_WIDTH];
        sel_y        = req_y[i*Y_WIDTH +: Y_WIDTH];
        sel_color    = req_color[i*COLOR_WIDTH +: COLOR_WIDTH];
        req_ready[i] = transfer;
      end
    end
  end

`ifdef PIXEL_COLOR_CHECK_EN
  logic color_bad;

  assign color_bad = !(sel_color inside {COLOR_BLACK, COLOR_WHITE, COLOR_RED, COLOR_GREEN, COLOR_BLUE});
  assign wr_color  = color_bad ? COLOR_BLACK : sel_color;

  // Sticky flag rises together with fb_valid for the offending write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      color_err <= 1'b0;
    end else if (transfer && color_bad) begin
      color_err <= 1'b1;
    end
  end
`else
  assign wr_color  = sel_color;
  assign color_err = 1'b0;
`endif

  // Rotation pointer and burst lock bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      owner     <= '0;
      locked    <= 1'b0;
      burst_cnt <= '0;
    end else if (transfer) begin
      if (req_lock[gidx] && (burst_next < 9'(MAX_BURST))) begin
        locked    <= 1'b1;
        owner     <= gidx;
        burst_cnt <= burst_next[7:0];
      end else begin
        locked    <= 1'b0;
        burst_cnt <= '0;
        ptr       <= ptr_next;
      end
    end else if (locked && !lock_hold) begin
      locked    <= 1'b0;
      burst_cnt <= '0;
    end
  end

  // Single registered write stage toward the framebuffer; holds while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_valid <= 1'b0;
      fb_x     <= '0;
      fb_y     <= '0;
      fb_color <= '0;
      fb_src   <= '0;
    end else if (accept) begin
      fb_valid <= transfer;
      if (transfer) begin
        fb_x     <= sel_x;
        fb_y     <= sel_y;
        fb_color <= wr_color;
        fb_src   <= gidx;
      end
    end
  end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb/tb_pixel_write_arbiter.sv - self-checking bench for pixel_write_arbiter
module tb_pixel_write_arbiter;
  import common_pkg::*;

  localparam int N  = 2;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int MB = 4;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic [N-1:0]             req_valid = '0;
  logic [N-1:0]             req_lock = '0;
  logic [N*XW-1:0]          req_x;
  logic [N*YW-1:0]          req_y;
  logic [N*COLOR_WIDTH-1:0] req_color;
  logic [N-1:0]             req_ready;
  logic                     fb_valid;
  logic                     fb_ready = 1'b1;
  logic [XW-1:0]            fb_x;
  logic [YW-1:0]            fb_y;
  logic [COLOR_WIDTH-1:0]   fb_color;
  logic [0:0]               fb_src;
  logic                     color_err;

  logic [XW-1:0]          px[N];
  logic [YW-1:0]          py[N];
  logic [COLOR_WIDTH-1:0] pc[N];

  int vectors = 0;
  int miscompares = 0;

  // reference model state: rotation start, lock owner (-1 = none), transfers in current lock run
  int m_ptr, m_owner, m_run;
  bit m_fbv, m_err;
  int m_x, m_y, m_c, m_src;
  int srcq[$];

  int exp_alt[6]  = '{0, 1, 0, 1, 0, 1};
  int exp_lock[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int exp_drop[7] = '{0, 0, 1, 1, 1, 1, 0};

  pixel_write_arbiter #(
    .NUM_REQ(N), .X_WIDTH(XW), .Y_WIDTH(YW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_lock(req_lock),
    .req_x(req_x), .req_y(req_y), .req_color(req_color),
    .req_ready(req_ready),
    .fb_valid(fb_valid), .fb_ready(fb_ready),
    .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_src(fb_src),
    .color_err(color_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_x     = '0;
    req_y     = '0;
    req_color = '0;
    for (int i = 0; i < N; i++) begin
      req_x[i*XW +: XW]                 = px[i];
      req_y[i*YW +: YW]                 = py[i];
      req_color[i*COLOR_WIDTH +: COLOR_WIDTH] = pc[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_color(input int c);
    return c inside {int'(COLOR_BLACK), int'(COLOR_WHITE), int'(COLOR_RED), int'(COLOR_GREEN), int'(COLOR_BLUE)};
  endfunction

  function automatic int winner(input logic [N-1:0] v);
    if (m_owner >= 0 && v[m_owner]) return m_owner;
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_run = 0;
    m_fbv = 0; m_err = 0;
    m_x = 0; m_y = 0; m_c = 0; m_src = 0;
  endtask

  // one clock: check at negedge against the model, then advance the model across the posedge
  task automatic cycle();
    int w;
    int run;
    bit acc, xfer;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    w = winner(req_valid);
    acc = !m_fbv || fb_ready;
    xfer = (w >= 0) && acc;
    exp_rdy = '0;
    if (xfer) exp_rdy[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("fb_valid", 32'(fb_valid), 32'(m_fbv));
    if (m_fbv) begin
      chk("fb_x", 32'(fb_x), m_x);
      chk("fb_y", 32'(fb_y), m_y);
      chk("fb_color", 32'(fb_color), m_c);
      chk("fb_src", 32'(fb_src), m_src);
    end
    chk("color_err", 32'(color_err), 32'(m_err));
    if (fb_valid && fb_ready) srcq.push_back(int'(fb_src));
    if (xfer) begin
      run = ((m_owner == w) ? m_run : 0) + 1;
      if (req_lock[w] && run < MB) begin
        m_owner = w; m_run = run;
      end else begin
        m_owner = -1; m_run = 0; m_ptr = (w + 1) % N;
      end
    end else if (m_owner >= 0 && !req_valid[m_owner]) begin
      m_owner = -1; m_run = 0;
    end
    if (acc) begin
      m_fbv = xfer;
      if (xfer) begin
        m_x = int'(px[w]); m_y = int'(py[w]); m_src = w;
`ifdef PIXEL_COLOR_CHECK_EN
        if (legal_color(int'(pc[w]))) m_c = int'(pc[w]);
        else begin m_c = int'(COLOR_BLACK); m_err = 1; end
`else
        m_c = int'(pc[w]);
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req_valid = '0;
    req_lock = '0;
    fb_ready = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_fb_valid", 32'(fb_valid), 0);
    chk("rst_fb_x", 32'(fb_x), 0);
    chk("rst_fb_y", 32'(fb_y), 0);
    chk("rst_fb_color", 32'(fb_color), 0);
    chk("rst_fb_src", 32'(fb_src), 0);
    chk("rst_color_err", 32'(color_err), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    reset_n = 1'b1;
    srcq.delete();
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      px[i] = XW'($urandom);
      py[i] = YW'($urandom);
      pc[i] = COLOR_WIDTH'($urandom_range(0, 4));
    end
  endtask

  task automatic check_seq(input string tag, input int exp[], input int n);
    chk({tag, "_len_ok"}, 32'(srcq.size() >= n), 1);
    for (int i = 0; i < n && i < srcq.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), srcq[i], exp[i]);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin px[i] = '0; py[i] = '0; pc[i] = '0; end
    model_reset();
    apply_reset();

    // both requesters continuously valid, no lock: strict alternation
    req_valid = 2'b11;
    for (int c = 0; c < 8; c++) begin rand_payload(); cycle(); end
    check_seq("alt", exp_alt, 6);

    // drain, then a single write stalled by the framebuffer
    req_valid = 2'b00;
    cycle(); cycle();
    req_valid = 2'b01; px[0] = 10'd5; py[0] = 9'd7; pc[0] = COLOR_RED; fb_ready = 1'b0;
    cycle();
    px[0] = 10'd6;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("stall_valid", 32'(fb_valid), 1);
      chk("stall_x", 32'(fb_x), 5);
      chk("stall_y", 32'(fb_y), 7);
      chk("stall_color", 32'(fb_color), 32'(COLOR_RED));
    end
    req_valid = 2'b00; fb_ready = 1'b1;
    cycle();
    chk("drain_valid", 32'(fb_valid), 0);
    cycle();

    // req0 locks continuously against req1: bursts of MB then one req1 write
    apply_reset();
    req_valid = 2'b11; req_lock = 2'b01;
    for (int c = 0; c < 12; c++) begin rand_payload(); cycle(); end
    check_seq("lock", exp_lock, 10);

    // lock owner drops valid after two writes; req1 takes over the same cycle and gets a full burst
    apply_reset();
    req_valid = 2'b11; req_lock = 2'b11;
    cycle(); cycle();
    req_valid = 2'b10;
    #1;
    chk("drop_grant", 32'(req_ready), 32'(2'b10));
    cycle();
    req_valid = 2'b11;
    for (int c = 0; c < 6; c++) cycle();
    check_seq("drop", exp_drop, 7);

    // asynchronous reset while a locked write is pending
    apply_reset();
    req_valid = 2'b01; req_lock = 2'b01;
    cycle(); cycle();
    chk("pre_rst_valid", 32'(fb_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(fb_valid), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    req_valid = 2'b11; req_lock = 2'b00;
    #1;
    chk("tie_after_reset", 32'(req_ready), 32'(2'b01));
    cycle(); cycle();

    // illegal color from req1
    req_valid = 2'b10; pc[1] = 4'd7; px[1] = 10'd33; py[1] = 9'd44;
    cycle();
`ifdef PIXEL_COLOR_CHECK_EN
    chk("illegal_color", 32'(fb_color), 32'(COLOR_BLACK));
    chk("illegal_err", 32'(color_err), 1);
`else
    chk("illegal_color", 32'(fb_color), 7);
    chk("illegal_err", 32'(color_err), 0);
`endif
    pc[1] = COLOR_GREEN;
    cycle(); cycle();

    // randomized traffic against the model
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      req_lock  = N'($urandom);
      fb_ready  = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        px[i] = XW'($urandom);
        py[i] = YW'($urandom);
        pc[i] = COLOR_WIDTH'($urandom_range(0, 7));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
